// File: rtl/fifo_pkg.sv
// Shared defaults and sizing helper for the synchronous FIFO.
// No logic here; imported by the storage and control modules.
package fifo_pkg;

  localparam int DEF_DATA_W    = 8;
  localparam int DEF_DEPTH     = 16;
  localparam int DEF_AFULL_TH  = DEF_DEPTH - 2;
  localparam int DEF_AEMPTY_TH = 2;

  // Occupancy must represent 0..DEPTH inclusive, hence one bit above the pointer width.
  function automatic int cnt_w(input int depth);
    return $clog2(depth) + 1;
  endfunction

endpackage

// File: rtl/fifo_mem.sv
// DEPTH x DATA_W storage: synchronous write, asynchronous (zero-latency) read.
// No flow control of its own; the caller only asserts we for accepted writes.
module fifo_mem #(
  parameter int DATA_W = 8,
  parameter int DEPTH  = 16
) (
  input  logic                     clk,
  input  logic                     we,
  input  logic [$clog2(DEPTH)-1:0] waddr,
  input  logic [DATA_W-1:0]        wdata,
  input  logic [$clog2(DEPTH)-1:0] raddr,
  output logic [DATA_W-1:0]        rdata
);

  logic [DATA_W-1:0] mem [DEPTH];

  // Contents are deliberately left unreset; valid data is tracked by the pointers.
  always_ff @(posedge clk) begin
    if (we) begin
      mem[waddr] <= wdata;
    end
  end

  assign rdata = mem[raddr];

endmodule

// File: rtl/fifo_sync_param.sv
// Single-clock FIFO: 1-cycle registered read (FWFT=0) or fall-through head (FWFT=1).
// Writes when full are dropped with an overflow pulse; reads when empty give an underflow pulse.
module fifo_sync_param
  import fifo_pkg::*;
#(
  parameter int DATA_W    = DEF_DATA_W,
  parameter int DEPTH     = DEF_DEPTH,
  parameter int AFULL_TH  = DEPTH - 2,
  parameter int AEMPTY_TH = DEF_AEMPTY_TH,
  parameter int FWFT      = 0
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic [DATA_W-1:0]      d_in,
  input  logic                   write,
  input  logic                   read,
  output logic [DATA_W-1:0]      d_out,
  output logic                   full,
  output logic                   empty,
  output logic                   almost_full,
  output logic                   almost_empty,
  output logic [$clog2(DEPTH):0] count,
  output logic                   overflow,
  output logic                   underflow
);

  localparam int AW    = $clog2(DEPTH);
  localparam int CNT_W = cnt_w(DEPTH);

  localparam logic [CNT_W-1:0] DEPTH_C  = CNT_W'(DEPTH);
  localparam logic [CNT_W-1:0] AFULL_C  = CNT_W'(AFULL_TH);
  localparam logic [CNT_W-1:0] AEMPTY_C = CNT_W'(AEMPTY_TH);

  logic [AW-1:0]     wr_ptr;
  logic [AW-1:0]     rd_ptr;
  logic [CNT_W-1:0]  cnt_q;
  logic [DATA_W-1:0] dout_q;
  logic [DATA_W-1:0] mem_rdata;
  logic              rd_ok;
  logic              wr_ok;

  // A full FIFO still takes a write when a read frees the head slot in the same cycle.
  assign rd_ok = read & ~empty;
  assign wr_ok = write & (~full | rd_ok);

  fifo_mem #(
    .DATA_W (DATA_W),
    .DEPTH  (DEPTH)
  ) u_mem (
    .clk   (clk),
    .we    (wr_ok),
    .waddr (wr_ptr),
    .wdata (d_in),
    .raddr (rd_ptr),
    .rdata (mem_rdata)
  );

  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr    <= '0;
      rd_ptr    <= '0;
      cnt_q     <= '0;
      dout_q    <= '0;
      overflow  <= 1'b0;
      underflow <= 1'b0;
    end else begin
      if (wr_ok) begin
        wr_ptr <= wr_ptr + AW'(1);
      end
      if (rd_ok) begin
        rd_ptr <= rd_ptr + AW'(1);
      end
      case ({wr_ok, rd_ok})
        2'b10:   cnt_q <= cnt_q + CNT_W'(1);
        2'b01:   cnt_q <= cnt_q - CNT_W'(1);
        default: cnt_q <= cnt_q;
      endcase
      overflow  <= write & ~wr_ok;
      underflow <= read & empty;
      if ((FWFT == 0) && rd_ok) begin
        dout_q <= mem_rdata;
      end
    end
  end

  assign count        = cnt_q;
  assign full         = (cnt_q == DEPTH_C);
  assign empty        = (cnt_q == '0);
  assign almost_full  = (cnt_q >= AFULL_C);
  assign almost_empty = (cnt_q <= AEMPTY_C);

  // Fall-through mode drives zero while empty so stale storage never leaks out.
  assign d_out = (FWFT != 0) ? (empty ? '0 : mem_rdata) : dout_q;

endmodule

// File: tb/tb_fifo_sync_param.sv
// Bench for fifo_sync_param: registered-read and fall-through instances share stimulus,
// both checked every cycle against a queue model, plus directed literal checks.
module tb_fifo_sync_param;

  localparam int DW = 8;
  localparam int DP = 16;
  localparam int AF = 14;
  localparam int AE = 2;

  logic          clk = 1'b0;
  logic          rst = 1'b0;
  logic [DW-1:0] d_in = '0;
  logic          write = 1'b0;
  logic          read = 1'b0;

  logic [DW-1:0] r_dout, f_dout;
  logic          r_full, r_empty, r_afull, r_aempty, r_ovf, r_unf;
  logic          f_full, f_empty, f_afull, f_aempty, f_ovf, f_unf;
  logic [4:0]    r_cnt, f_cnt;

  int n_cmp = 0;
  int n_bad = 0;

  int  q[$];
  int  m_dout;
  bit  m_ovf, m_unf;

  always #5 clk = ~clk;

  fifo_sync_param #(.DATA_W(DW), .DEPTH(DP), .AFULL_TH(AF), .AEMPTY_TH(AE), .FWFT(0)) u_reg (
    .clk(clk), .rst(rst), .d_in(d_in), .write(write), .read(read),
    .d_out(r_dout), .full(r_full), .empty(r_empty), .almost_full(r_afull),
    .almost_empty(r_aempty), .count(r_cnt), .overflow(r_ovf), .underflow(r_unf)
  );

  fifo_sync_param #(.DATA_W(DW), .DEPTH(DP), .AFULL_TH(AF), .AEMPTY_TH(AE), .FWFT(1)) u_fwft (
    .clk(clk), .rst(rst), .d_in(d_in), .write(write), .read(read),
    .d_out(f_dout), .full(f_full), .empty(f_empty), .almost_full(f_afull),
    .almost_empty(f_aempty), .count(f_cnt), .overflow(f_ovf), .underflow(f_unf)
  );

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // Reference behaviour: occupancy is the queue length, reads pop the head.
  task automatic model_step();
    bit e, f, rd_ok, wr_ok;
    if (rst) begin
      q.delete();
      m_dout = 0;
      m_ovf  = 0;
      m_unf  = 0;
    end else begin
      e     = (q.size() == 0);
      f     = (q.size() == DP);
      rd_ok = read && !e;
      wr_ok = write && (!f || rd_ok);
      m_unf = read && e;
      m_ovf = write && !wr_ok;
      if (rd_ok) m_dout = q.pop_front();
      if (wr_ok) q.push_back(int'(d_in));
    end
  endtask

  task automatic check_all();
    int n;
    n = q.size();
    chk("r_count",  32'(r_cnt),    32'(n));
    chk("f_count",  32'(f_cnt),    32'(n));
    chk("r_full",   32'(r_full),   32'(n == DP));
    chk("f_full",   32'(f_full),   32'(n == DP));
    chk("r_empty",  32'(r_empty),  32'(n == 0));
    chk("f_empty",  32'(f_empty),  32'(n == 0));
    chk("r_afull",  32'(r_afull),  32'(n >= AF));
    chk("f_afull",  32'(f_afull),  32'(n >= AF));
    chk("r_aempty", 32'(r_aempty), 32'(n <= AE));
    chk("f_aempty", 32'(f_aempty), 32'(n <= AE));
    chk("r_ovf",    32'(r_ovf),    32'(m_ovf));
    chk("f_ovf",    32'(f_ovf),    32'(m_ovf));
    chk("r_unf",    32'(r_unf),    32'(m_unf));
    chk("f_unf",    32'(f_unf),    32'(m_unf));
    chk("r_dout",   32'(r_dout),   32'(m_dout));
    chk("f_dout",   32'(f_dout),   (n == 0) ? 32'd0 : 32'(q[0]));
  endtask

  task automatic tick(input logic rs, input logic w, input logic r, input logic [DW-1:0] d);
    rst   = rs;
    write = w;
    read  = r;
    d_in  = d;
    model_step();
    @(posedge clk);
    #1;
    check_all();
  endtask

  int wp_tab [6] = '{70, 30, 50, 95, 90, 10};
  int rp_tab [6] = '{30, 70, 50, 95, 10, 90};

  initial begin
    // Reset then idle
    tick(1, 0, 0, 8'h00);
    tick(0, 0, 0, 8'h00);
    tick(0, 0, 0, 8'h00);
    chk("idle_count",  32'(r_cnt),    32'd0);
    chk("idle_empty",  32'(r_empty),  32'd1);
    chk("idle_aempty", 32'(r_aempty), 32'd1);
    chk("idle_full",   32'(r_full),   32'd0);
    chk("idle_dout",   32'(r_dout),   32'd0);

    // Fill 1..16 and watch the threshold flags move
    for (int i = 1; i <= 16; i++) begin
      tick(0, 1, 0, DW'(i));
      chk("fill_count",  32'(r_cnt),    32'(i));
      chk("fill_aempty", 32'(r_aempty), 32'(i <= 2));
      chk("fill_afull",  32'(r_afull),  32'(i >= 14));
      chk("fill_full",   32'(r_full),   32'(i == 16));
    end
    tick(0, 1, 0, 8'hAA);
    chk("ovf_pulse", 32'(r_ovf), 32'd1);
    chk("ovf_count", 32'(r_cnt), 32'd16);
    tick(0, 0, 0, 8'h00);
    chk("ovf_once",  32'(r_ovf), 32'd0);

    // Drain, data must come back 1..16
    for (int i = 1; i <= 16; i++) begin
      tick(0, 0, 1, 8'h00);
      chk("drain_dout", 32'(r_dout), 32'(i));
    end
    chk("drain_empty", 32'(r_empty), 32'd1);
    tick(0, 0, 1, 8'h00);
    chk("unf_pulse", 32'(r_unf),  32'd1);
    chk("unf_dout",  32'(r_dout), 32'd16);
    chk("unf_count", 32'(r_cnt),  32'd0);

    // Read+write on empty: write only
    tick(0, 1, 1, 8'h77);
    chk("rw_empty_unf",   32'(r_unf), 32'd1);
    chk("rw_empty_count", 32'(r_cnt), 32'd1);
    tick(0, 0, 1, 8'h00);
    chk("rw_empty_data",  32'(r_dout), 32'h77);

    // Full with concurrent read+write across pointer wrap
    for (int i = 0; i < 16; i++) tick(0, 1, 0, DW'($urandom_range(255)));
    for (int i = 0; i < 20; i++) begin
      tick(0, 1, 1, 8'h55);
      chk("wrap_count", 32'(r_cnt), 32'd16);
      chk("wrap_ovf",   32'(r_ovf), 32'd0);
    end
    chk("wrap_dout", 32'(r_dout), 32'h55);

    // Fall-through into an empty FIFO
    tick(1, 0, 0, 8'h00);
    tick(0, 1, 0, 8'h3C);
    chk("fwft_empty", 32'(f_empty), 32'd0);
    chk("fwft_dout",  32'(f_dout),  32'h3C);
    tick(0, 0, 1, 8'h00);
    chk("fwft_empty2", 32'(f_empty), 32'd1);
    chk("fwft_dout2",  32'(f_dout),  32'd0);

    // Reset wins over concurrent read+write at count 8
    for (int i = 0; i < 8; i++) tick(0, 1, 0, DW'(8'hC0 + i));
    chk("pre_rst_count", 32'(r_cnt), 32'd8);
    tick(1, 1, 1, 8'hEE);
    chk("rst_count",  32'(r_cnt),    32'd0);
    chk("rst_empty",  32'(r_empty),  32'd1);
    chk("rst_aempty", 32'(r_aempty), 32'd1);
    chk("rst_full",   32'(r_full),   32'd0);
    chk("rst_afull",  32'(r_afull),  32'd0);
    chk("rst_ovf",    32'(r_ovf),    32'd0);
    chk("rst_unf",    32'(r_unf),    32'd0);
    chk("rst_dout",   32'(r_dout),   32'd0);
    chk("rst_fdout",  32'(f_dout),   32'd0);

    // Randomised phases with varying read/write pressure
    for (int p = 0; p < 6; p++) begin
      for (int c = 0; c < 500; c++) begin
        tick(logic'($urandom_range(299) == 0),
             logic'($urandom_range(99) < wp_tab[p]),
             logic'($urandom_range(99) < rp_tab[p]),
             DW'($urandom_range(255)));
      end
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule

// File: doc/fifo_sync_param.md
FIFO_SYNC_PARAM -- requirements
Module: fifo_sync_param

Interface
REQ-001 SHALL have parameter DATA_W, default 8, data word width in bits.
REQ-002 SHALL have parameter DEPTH, default 16, entries; power of two, >= 4.
REQ-003 SHALL have parameter AFULL_TH, default DEPTH-2, almost_full threshold (entries).
REQ-004 SHALL have parameter AEMPTY_TH, default 2, almost_empty threshold (entries).
REQ-005 SHALL have parameter FWFT, default 0, read mode: 0 = registered read, 1 = first-word-fall-through.
REQ-006 SHALL have port clk  input  1  sole clock; all state updates on rising edge.
REQ-007 SHALL have port rst  input  1  reset; one clock, synchronous, active-high.
REQ-008 SHALL have port d_in  input  DATA_W  write data.
REQ-009 SHALL have port write  input  1  write request.
REQ-010 SHALL have port read  input  1  read request.
REQ-011 SHALL have port d_out  output  DATA_W  read data.
REQ-012 SHALL have ports full, empty, almost_full, almost_empty  output  1 each  occupancy flags.
REQ-013 SHALL have port count  output  CNT_W = clog2(DEPTH)+1  current occupancy, 0..DEPTH.
REQ-014 SHALL have ports overflow, underflow  output  1 each  one-cycle error pulses.

Function
REQ-015 Read SHALL be accepted iff read=1 and empty=0.
REQ-016 Write SHALL be accepted iff write=1 and (full=0 or read accepted same cycle); when full with simultaneous read and write, both are accepted and count stays DEPTH.
REQ-017 count SHALL be registered: +1 on write-only, -1 on read-only, unchanged on both or neither.
REQ-018 full SHALL equal (count==DEPTH); empty (count==0); almost_full (count>=AFULL_TH); almost_empty (count<=AEMPTY_TH); all derived from the count register, no extra latency.
REQ-019 Read and write pointers SHALL be clog2(DEPTH) bits and wrap DEPTH-1 -> 0 without special handling.
REQ-020 FWFT=0: on accepted read, d_out SHALL take the head entry at the next rising edge (1-cycle latency); otherwise d_out holds its value.
REQ-021 FWFT=1: d_out SHALL present the head entry combinationally whenever empty=0, and 0 when empty=1; a read advances to the next entry at the next edge.
REQ-022 Write data SHALL be readable no earlier than the cycle after its write edge (empty deasserts one cycle after the first write into an empty FIFO).
REQ-023 overflow SHALL pulse high one cycle after a cycle with write=1 that is not accepted; the data is discarded and state is unchanged.
REQ-024 underflow SHALL pulse high one cycle after a cycle with read=1 while empty=1; pointers, count and d_out are unchanged.
REQ-025 Simultaneous read and write on an empty FIFO SHALL accept only the write (read is an underflow).

Reset
REQ-026 rst=1 at a rising edge SHALL take priority over read/write in that cycle and discard all contents.
REQ-027 After reset: count=0, empty=1, almost_empty=1, full=0, almost_full=0, overflow=0, underflow=0, d_out=0, both pointers=0.
REQ-028 Storage array SHALL NOT be reset.

Structure
REQ-029 Package fifo_pkg SHALL hold default constants (DATA_W, DEPTH, thresholds) and the count-width function.
REQ-030 Storage SHALL be a sub-module fifo_mem: DEPTH x DATA_W, one synchronous write port, one asynchronous read port.
REQ-031 Pointer/count/flag control SHALL reside in fifo_sync_param.

Verification (DATA_W=8, DEPTH=16, AFULL_TH=14, AEMPTY_TH=2)
REQ-032 Reset then idle -> count=0, empty=1, almost_empty=1, full=0, d_out=0.
REQ-033 Write 1..16 back-to-back, FWFT=0 -> almost_empty drops at count=3, almost_full rises at count=14, full=1 at count=16; 17th write (0xAA) -> overflow pulses once, count stays 16.
REQ-034 From full, read 16 times -> d_out sequence 1..16 each one cycle after its read, empty=1 after last; extra read -> underflow pulse, d_out stays 16.
REQ-035 Full, simultaneous read+write of 0x55 for 20 cycles (pointer wrap) -> count stays 16, no overflow, read data in write order.
REQ-036 FWFT=1, write 0x3C into empty -> next cycle empty=0, d_out=0x3C without read; read -> empty=1, d_out=0.
REQ-037 Count=8, assert rst with read=write=1 -> next cycle all REQ-027 values, no error pulses.
